// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD-to-binary converter.
// Holds widths, iteration count and a digit-range check helper.
package bcd_pkg;

    localparam int BIN_W   = 10;
    localparam int DIGITS  = 3;
    localparam int BCD_W   = 4;
    localparam int SHIFT_W = 22;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // True when a nibble is not a legal 8421 digit (10..15)
    function automatic logic bcd_bad(input logic [BCD_W-1:0] d);
        return d[3] & (d[2] | d[1]);
    endfunction

endpackage

// File: rtl/bin_from_bcd_8421_if.sv
// Request/result bundle of the BCD-to-binary converter.
// master: drives start + digits, slave: drives busy/data_valid/data/err.
interface bin_from_bcd_8421_if;
    import bcd_pkg::*;

    logic             start;
    logic [BCD_W-1:0] hun;
    logic [BCD_W-1:0] ten;
    logic [BCD_W-1:0] unit;
    logic             busy;
    logic             data_valid;
    logic [BIN_W-1:0] data;
    logic             err;

    modport master (
        output start, hun, ten, unit,
        input  busy, data_valid, data, err
    );

    modport slave (
        input  start, hun, ten, unit,
        output busy, data_valid, data, err
    );

endinterface

// File: rtl/bcd_digit_sub3.sv
// Combinational correction cell for one BCD digit after a right shift.
// Ports: d (4-bit shifted digit) -> q (d >= 8 ? d - 3 : d).
module bcd_digit_sub3
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q
);

    assign q = d[3] ? d - BCD_W'(3) : d;

endmodule

// File: rtl/bin_from_bcd_8421.sv
// Sequential 3-digit BCD to 10-bit binary converter (shift right, sub 3).
// Ports: pll_clk_33m, sys_rst_n (async low), bus (slave: start/digits in,
// busy/data_valid/data/err out). One iteration per clock, 10 iterations.
module bin_from_bcd_8421 #(
    parameter int BIN_W  = bcd_pkg::BIN_W,
    parameter int DIGITS = bcd_pkg::DIGITS
) (
    input  logic                    pll_clk_33m,
    input  logic                    sys_rst_n,
    bin_from_bcd_8421_if.slave      bus
);
    import bcd_pkg::*;

    localparam int SW    = DIGITS * BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W);

    state_t           state;
    logic [SW-1:0]    sreg;
    logic [CNT_W-1:0] cnt;
    logic             busy_r;
    logic             valid_r;
    logic             err_r;
    logic [BIN_W-1:0] data_r;

    logic [SW-1:0]    shifted;
    logic [SW-1:0]    corr;
    logic             digits_ok;

    assign shifted = sreg >> 1;
    assign corr[BIN_W-1:0] = shifted[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit_sub3 u_sub3 (
            .d (shifted[BIN_W + g*BCD_W +: BCD_W]),
            .q (corr[BIN_W + g*BCD_W +: BCD_W])
        );
    end

    assign digits_ok = !(bcd_bad(bus.hun) |
                         bcd_bad(bus.ten) |
                         bcd_bad(bus.unit));

    always_ff @(posedge pll_clk_33m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            data_r  <= '0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (digits_ok) begin
                            sreg   <= {bus.hun, bus.ten, bus.unit,
                                       {BIN_W{1'b0}}};
                            cnt    <= '0;
                            busy_r <= 1'b1;
                            state  <= SHIFT;
                        end else begin
                            err_r  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    sreg <= corr;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        data_r  <= corr[BIN_W-1:0];
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.data_valid = valid_r;
    assign bus.data       = data_r;
    assign bus.err        = err_r;

endmodule

// File: tb/tb_bin_from_bcd_8421.sv
// Self-checking bench for bin_from_bcd_8421: vector table, random digits
// against an arithmetic model, and hand-written multi-cycle sequences.
module tb_bin_from_bcd_8421;

    logic pll_clk_33m = 1'b0;
    logic sys_rst_n   = 1'b0;

    always #15 pll_clk_33m = ~pll_clk_33m;

    bin_from_bcd_8421_if bus ();

    bin_from_bcd_8421 dut (
        .pll_clk_33m (pll_clk_33m),
        .sys_rst_n   (sys_rst_n),
        .bus         (bus)
    );

    int nvec = 0;
    int nbad = 0;

    typedef struct {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        int         exp_data;
        bit         exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one start and observe 15 sample points after the sampling edge.
    task automatic apply(input logic [3:0] h, t, u,
                         output int lat, output int vcnt,
                         output bit errp, output int bcyc,
                         output int d);
        @(negedge pll_clk_33m);
        bus.start = 1'b1;
        bus.hun = h; bus.ten = t; bus.unit = u;
        @(negedge pll_clk_33m);
        bus.start = 1'b0;
        lat = 0; vcnt = 0; errp = 0; bcyc = 0;
        for (int i = 1; i <= 15; i++) begin
            if (bus.err) errp = 1;
            if (bus.busy) bcyc++;
            if (bus.data_valid) begin
                vcnt++;
                if (lat == 0) lat = i;
                if (bus.err) check("valid_and_err", 1, 0);
            end
            if (i < 15) @(negedge pll_clk_33m);
        end
        d = int'(bus.data);
    endtask

    task automatic run_check(input string tag, input logic [3:0] h, t, u,
                             input int exp_data, input bit exp_err);
        int lat, vcnt, bcyc, d;
        bit errp;
        apply(h, t, u, lat, vcnt, errp, bcyc, d);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_err"}, int'(errp), int'(exp_err));
        check({tag, "_vcnt"}, vcnt, exp_err ? 0 : 1);
        check({tag, "_lat"}, lat, exp_err ? 0 : 11);
        check({tag, "_busy"}, bcyc, exp_err ? 0 : 10);
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge pll_clk_33m);
            if (bus.data_valid) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int last;
        int cyc;
        int vc;
        bit eseen;
        logic [3:0] h, t, u;
        bit e;

        bus.start = 1'b0;
        bus.hun = '0; bus.ten = '0; bus.unit = '0;

        tbl[0] = '{4'd0, 4'd0, 4'd0, 0,   1'b0};
        tbl[1] = '{4'd9, 4'd9, 4'd9, 999, 1'b0};
        tbl[2] = '{4'd2, 4'd5, 4'd6, 256, 1'b0};
        tbl[3] = '{4'd0, 4'd1, 4'd2, 12,  1'b0};
        tbl[4] = '{4'd0, 4'hA, 4'd0, 12,  1'b1};
        tbl[5] = '{4'hF, 4'd3, 4'd3, 12,  1'b1};

        #40;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.data_valid), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_data", int'(bus.data), 0);
        @(negedge pll_clk_33m);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_check($sformatf("tbl%0d", i), tbl[i].h, tbl[i].t,
                      tbl[i].u, tbl[i].exp_data, tbl[i].exp_err);
        last = 12;

        // random digits, occasionally illegal nibbles
        for (int i = 0; i < 25; i++) begin
            h = 4'($urandom_range(0, 9));
            t = 4'($urandom_range(0, 9));
            u = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) t = 4'($urandom_range(10, 15));
            e = (h > 9) || (t > 9) || (u > 9);
            if (!e) last = h * 100 + t * 10 + u;
            run_check($sformatf("rnd%0d", i), h, t, u, last, e);
        end

        // back-to-back: second start in the data_valid cycle
        @(negedge pll_clk_33m);
        bus.start = 1'b1; bus.hun = 4'd5; bus.ten = 4'd0; bus.unit = 4'd9;
        @(negedge pll_clk_33m);
        bus.start = 1'b0;
        cyc = 0;
        for (int i = 2; i <= 20; i++) begin
            @(negedge pll_clk_33m);
            if (bus.data_valid) begin
                cyc = i;
                break;
            end
        end
        check("b2b_first_lat", cyc, 11);
        check("b2b_first_data", int'(bus.data), 509);
        bus.start = 1'b1; bus.hun = 4'd0; bus.ten = 4'd4; bus.unit = 4'd2;
        @(negedge pll_clk_33m);
        bus.start = 1'b0;
        check("b2b_accepted", int'(bus.busy), 1);
        wait_valid("b2b_second", cyc);
        check("b2b_second_lat", cyc + 1, 11);
        check("b2b_second_data", int'(bus.data), 42);

        // starts while busy are ignored
        @(negedge pll_clk_33m);
        bus.start = 1'b1; bus.hun = 4'd1; bus.ten = 4'd2; bus.unit = 4'd3;
        @(negedge pll_clk_33m);
        bus.start = 1'b0;
        vc = 0; eseen = 0;
        for (int i = 1; i <= 25; i++) begin
            if (bus.data_valid) vc++;
            if (bus.err) eseen = 1;
            if (i == 3 || i == 7) begin
                bus.start = 1'b1;
                bus.hun = 4'd9; bus.ten = (i == 3) ? 4'hB : 4'd9;
                bus.unit = 4'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge pll_clk_33m);
        end
        check("busy_ign_vcnt", vc, 1);
        check("busy_ign_err", int'(eseen), 0);
        check("busy_ign_data", int'(bus.data), 123);

        // reset mid-conversion
        @(negedge pll_clk_33m);
        bus.start = 1'b1; bus.hun = 4'd7; bus.ten = 4'd7; bus.unit = 4'd7;
        @(negedge pll_clk_33m);
        bus.start = 1'b0;
        repeat (4) @(negedge pll_clk_33m);
        #3 sys_rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_data", int'(bus.data), 0);
        check("mid_rst_valid", int'(bus.data_valid), 0);
        check("mid_rst_err", int'(bus.err), 0);
        @(negedge pll_clk_33m);
        sys_rst_n = 1'b1;
        vc = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge pll_clk_33m);
            if (bus.data_valid || bus.busy) vc++;
        end
        check("post_rst_idle", vc, 0);
        run_check("post_rst", 4'd0, 4'd0, 4'd1, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/bin_from_bcd_8421.md
Name: bin_from_bcd_8421

Overview:
Sequential converter from 3-digit 8421 BCD to a 10-bit unsigned binary value. It is the inverse of the existing binary-to-BCD path. It runs the reverse shift-and-subtract-3 algorithm, one iteration per clock, under a start/valid handshake. It sits between keypad/UART BCD entry logic and the threshold and configuration registers of the sensor datapath.

Parameters:
BIN_W, 10, binary output width; equals the iteration count. Only the default is verified.
DIGITS, 3, number of BCD digits (hun, ten, unit). Only the default is verified.

Ports:
pll_clk_33m  input  1  system clock, 33 MHz
sys_rst_n  input  1  reset, asynchronous, active-low
start  input  1  single-cycle request; digits are sampled on the same edge
hun  input  4  hundreds BCD digit
ten  input  4  tens BCD digit
unit  input  4  units BCD digit
busy  output  1  high while a conversion is in progress
data_valid  output  1  one-cycle pulse; data holds a new result
data  output  10  binary result, held until the next successful conversion
err  output  1  one-cycle pulse; the start was rejected because a digit was greater than 9

Behaviour:
- Reset (asynchronous, active-low): state IDLE, busy=0, data_valid=0, err=0, data=0, shift register=0, iteration counter=0.
- Reset asserted mid-conversion aborts the conversion. No data_valid is produced and data returns to 0.
- FSM states: IDLE and SHIFT.
- IDLE, start=1 on edge N, all digits at most 9:
  - load the 22-bit register as {hun, ten, unit, 10'b0};
  - counter <= 0, busy <= 1, state -> SHIFT.
- IDLE, start=1 on edge N, any digit greater than 9:
  - err <= 1 for exactly one cycle;
  - state stays IDLE, busy stays 0;
  - data and data_valid are unchanged (no pulse).
- SHIFT, each edge performs one iteration:
  - shift the register right by 1 (the LSB of unit enters bit 9 of the binary field);
  - then, in each shifted BCD digit, any value of 8 or more has 3 subtracted;
  - shift and correction happen in the same cycle (combinational correction feeding the register);
  - counter increments.
- On the edge where counter==BIN_W-1 (edge N+10):
  - data <= corrected binary field [9:0];
  - data_valid <= 1 for one cycle, busy <= 0, state -> IDLE.
- Latency: data_valid is high in the cycle following edge N+10. There are 10 clocks from the start-sampling edge. Throughput is one conversion per 11 cycles.
- start while busy=1 is ignored: not queued, and no err.
- start in the cycle where data_valid=1 is legal (state is IDLE) and is accepted.
- Width rule: the maximum input 999 equals 0x3E7 and fits in 10 bits, so no overflow is possible. BCD digits are zero after the final iteration.
- data_valid and err are never high in the same cycle.

Decomposition:
- Shared package bcd_pkg holds:
  - BIN_W = 10, DIGITS = 3, BCD_W = 4, SHIFT_W = 22;
  - the state encoding: IDLE = 1'b0, SHIFT = 1'b1.
- One natural sub-module, bcd_digit_sub3: a purely combinational 4-bit in/out cell that outputs (d >= 8) ? d - 3 : d. It is instantiated once per digit.
- The FSM, counter, shift register and output registers stay in the top module.

Test Plan:
- hun=0, ten=0, unit=0, start pulse -> busy high for 10 cycles; data_valid pulse one cycle after edge N+10; data=0.
- 9/9/9 -> data=999 (10'h3E7); then 2/5/6 -> data=256 (10'h100); then 0/1/2 -> data=12.
- Back-to-back: 5/0/9 start, then 0/4/2 start asserted in the data_valid cycle -> data=509, followed 11 cycles later by data=42.
- ten=4'hA with start -> err pulse one cycle later; busy stays 0; no data_valid; data keeps its previous value.
- start (any digits) asserted at cycles 3 and 7 of a 1/2/3 conversion -> ignored; exactly one data_valid; data=123; err stays 0.
- sys_rst_n low at cycle 5 of a 7/7/7 conversion -> all outputs 0 immediately; no data_valid after release; next start with 0/0/1 gives data=1.
